// File: rtl/p7_seq_alu.sv
// Registered ALU with N/V/Z/C status register and a WIDTH-cycle shift-add multiplier.
// state  | meaning
// S_IDLE | ready; single-cycle ops complete on the accepting edge
// S_MUL  | multiply in progress, one shift-add iteration per cycle
module p7_seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    input  logic             loads,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             N,
    output logic             V,
    output logic             Z,
    output logic             C
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_MVN = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;
    localparam logic [2:0] OP_ASR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
    logic [WIDTH-1:0]   mplier_q;
    logic               loads_q;
    logic               accept, is_mul, mul_last;
    logic [SW-1:0]      sh;
    logic [WIDTH:0]     sum, diff, lsl_t, lsr_t, asr_t;
    logic [WIDTH-1:0]   res;
    logic               res_v, res_c;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (ALUop == OP_MUL);
    assign mul_last = (state_q == S_MUL) && (cnt_q == SW'(WIDTH - 1));
    assign acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Shifts carry one extra bit so the last bit shifted out lands in the spare position.
    always_comb begin
        sh    = Bin[SW-1:0];
        sum   = {1'b0, Ain} + {1'b0, Bin};
        diff  = {1'b0, Ain} - {1'b0, Bin};
        lsl_t = {1'b0, Ain} << sh;
        lsr_t = {Ain, 1'b0} >> sh;
        asr_t = $unsigned($signed({Ain, 1'b0}) >>> sh);
        res   = '0;
        res_v = 1'b0;
        res_c = 1'b0;
        case (ALUop)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (sum[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = ~diff[WIDTH];
                res_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (diff[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND: res = Ain & Bin;
            OP_MVN: res = ~Bin;
            OP_LSL: begin
                res   = lsl_t[WIDTH-1:0];
                res_c = lsl_t[WIDTH];
            end
            OP_LSR: begin
                res   = lsr_t[WIDTH:1];
                res_c = lsr_t[0];
            end
            OP_ASR: begin
                res   = asr_t[WIDTH:1];
                res_c = asr_t[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul) state_d = S_MUL;
            S_MUL:   if (mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            loads_q   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            N         <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            C         <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && is_mul) begin
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, Ain};
                mplier_q <= Bin;
                loads_q  <= loads;
            end else if (accept) begin
                out       <= res;
                out_valid <= 1'b1;
                if (loads) begin
                    N <= res[WIDTH-1];
                    V <= res_v;
                    Z <= (res == '0);
                    C <= res_c;
                end
            end else if (state_q == S_MUL) begin
                cnt_q    <= cnt_q + SW'(1);
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                // Final iteration: the full product is available combinationally in acc_nxt.
                if (mul_last) begin
                    out       <= acc_nxt[WIDTH-1:0];
                    out_valid <= 1'b1;
                    if (loads_q) begin
                        N <= acc_nxt[WIDTH-1];
                        V <= |acc_nxt[2*WIDTH-1:WIDTH];
                        Z <= (acc_nxt[WIDTH-1:0] == '0);
                        C <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_p7_seq_alu.sv
// Scoreboard bench for p7_seq_alu: a 16-bit and an 8-bit instance driven by directed steps.
module tb_p7_seq_alu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset16, iv16, ir16, ld16, ov16, n16, v16, z16, c16;
    logic [15:0] a16, b16, o16;
    logic [2:0]  op16;
    logic        reset8, iv8, ir8, ld8, ov8, n8, v8, z8, c8;
    logic [7:0]  a8, b8, o8;
    logic [2:0]  op8;

    p7_seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset16), .in_valid(iv16), .in_ready(ir16),
        .Ain(a16), .Bin(b16), .ALUop(op16), .loads(ld16),
        .out_valid(ov16), .out(o16), .N(n16), .V(v16), .Z(z16), .C(c16)
    );

    p7_seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .in_valid(iv8), .in_ready(ir8),
        .Ain(a8), .Bin(b8), .ALUop(op8), .loads(ld8),
        .out_valid(ov8), .out(o8), .N(n8), .V(v8), .Z(z8), .C(c8)
    );

    typedef struct {
        logic [15:0] r;
        logic [3:0]  nvzc;
    } exp_t;

    exp_t        q16[$], q8[$];
    exp_t        e16, e8;
    int          errors = 0, checks = 0;
    int          pulses16 = 0, pulses8 = 0;
    logic [3:0]  fl16 = 4'b0, fl8 = 4'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one operation at width w, written arithmetically.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, output logic [31:0] r,
                                  output logic v, output logic c);
        logic [63:0] mask, t, ae;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        sh   = int'(b) & (w - 1);
        r = '0; v = 1'b0; c = 1'b0; t = '0;
        case (op)
            3'd0: begin
                t = 64'(a) + 64'(b);
                r = 32'(t & mask);
                c = t[w];
                v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd1: begin
                r = 32'((64'(a) - 64'(b)) & mask);
                c = (a >= b);
                v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: r = a & b;
            3'd3: r = 32'(~64'(b) & mask);
            3'd4: begin
                t = 64'(a) << sh;
                r = 32'(t & mask);
                c = (sh == 0) ? 1'b0 : a[w-sh];
            end
            3'd5: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh-1];
            end
            3'd6: begin
                ae = 64'(a);
                if (a[w-1]) ae = ae | ~mask;
                r = 32'((ae >> sh) & mask);
                c = (sh == 0) ? 1'b0 : a[sh-1];
            end
            default: begin
                t = 64'(a) * 64'(b);
                r = 32'(t & mask);
                v = ((t >> w) != 64'd0);
            end
        endcase
    endfunction

    task automatic push16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input logic ld);
        logic [31:0] r; logic v, c;
        model(16, 32'(a), 32'(b), op, r, v, c);
        if (ld) fl16 = {r[15], v, (r[15:0] == 16'h0), c};
        q16.push_back('{r[15:0], fl16});
    endtask

    task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ld);
        logic [31:0] r; logic v, c;
        model(8, 32'(a), 32'(b), op, r, v, c);
        if (ld) fl8 = {r[7], v, (r[7:0] == 8'h0), c};
        q8.push_back('{{8'h0, r[7:0]}, fl8});
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input logic ld);
        int guard = 0;
        @(negedge clk);
        a16 = a; b16 = b; op16 = op; ld16 = ld; iv16 = 1'b1;
        while (!ir16 && guard < 100) begin @(negedge clk); guard++; end
        check("ready16", 32'(ir16), 32'd1);
        push16(a, b, op, ld);
        @(posedge clk);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ld);
        int guard = 0;
        @(negedge clk);
        a8 = a; b8 = b; op8 = op; ld8 = ld; iv8 = 1'b1;
        while (!ir8 && guard < 100) begin @(negedge clk); guard++; end
        check("ready8", 32'(ir8), 32'd1);
        push8(a, b, op, ld);
        @(posedge clk);
    endtask

    task automatic wait_done16();
        int guard = 0;
        do begin @(negedge clk); #1; guard++; end while (q16.size() != 0 && guard < 200);
        check("drain16", 32'(q16.size()), 32'd0);
    endtask

    task automatic wait_done8();
        int guard = 0;
        do begin @(negedge clk); #1; guard++; end while (q8.size() != 0 && guard < 200);
        check("drain8", 32'(q8.size()), 32'd0);
    endtask

    // Counts negedges until out_valid while presenting an ignored ADD request during the multiply.
    task automatic mul_timing16(output int lat, output int lows);
        bit seen = 1'b0;
        lat = -1; lows = 0;
        for (int j = 1; j <= 60 && !seen; j++) begin
            @(negedge clk);
            if (j == 1) begin op16 = 3'b000; a16 = 16'h1111; b16 = 16'h2222; end
            if (j >= 15) iv16 = 1'b0;
            if (!ir16) lows++;
            if (ov16) begin seen = 1'b1; lat = j - 1; end
        end
    endtask

    always @(negedge clk) begin
        if (!reset16 && ov16) begin
            pulses16++;
            if (q16.size() == 0) check("pulse16_expected", 32'(q16.size()), 32'd1);
            else begin
                e16 = q16.pop_front();
                check("out16", 32'(o16), 32'(e16.r));
                check("flags16", 32'({n16, v16, z16, c16}), 32'(e16.nvzc));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset8 && ov8) begin
            pulses8++;
            if (q8.size() == 0) check("pulse8_expected", 32'(q8.size()), 32'd1);
            else begin
                e8 = q8.pop_front();
                check("out8", 32'(o8), 32'(e8.r));
                check("flags8", 32'({n8, v8, z8, c8}), 32'(e8.nvzc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lows, p, ll, lo;
        bit seen;
        reset16 = 1'b1; iv16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; ld16 = 1'b0;
        reset8  = 1'b1; iv8  = 1'b0; a8  = '0; b8  = '0; op8  = '0; ld8  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset16 = 1'b0; reset8 = 1'b0;
        #1;
        check("rst_out16", 32'(o16), 32'd0);
        check("rst_valid16", 32'(ov16), 32'd0);
        check("rst_flags16", 32'({n16, v16, z16, c16}), 32'd0);
        check("rst_ready16", 32'(ir16), 32'd1);
        check("rst_out8", 32'(o8), 32'd0);

        // ADD overflow into the sign bit
        issue16(16'h7FFF, 16'h0001, 3'b000, 1'b1);
        @(negedge clk); iv16 = 1'b0;
        wait_done16();
        check("add_pulse_len", 32'(ov16), 32'd0);
        check("add_out", 32'(o16), 32'h8000);
        check("add_flags", 32'({n16, v16, z16, c16}), 32'b1100);

        // CMP equal, then AND without status load
        issue16(16'h0005, 16'h0005, 3'b001, 1'b1);
        issue16(16'hF0F0, 16'h0F0F, 3'b010, 1'b0);
        @(negedge clk); iv16 = 1'b0;
        wait_done16();
        check("and_out", 32'(o16), 32'h0000);
        check("cmp_flags_held", 32'({n16, v16, z16, c16}), 32'b0011);

        // Shifts, including sh==0 from Bin=0x0010
        issue16(16'h8001, 16'h0001, 3'b110, 1'b1);
        @(negedge clk); iv16 = 1'b0;
        wait_done16();
        check("asr_out", 32'(o16), 32'hC000);
        check("asr_flags", 32'({n16, v16, z16, c16}), 32'b1001);
        issue16(16'h1234, 16'h0010, 3'b100, 1'b1);
        @(negedge clk); iv16 = 1'b0;
        wait_done16();
        check("lsl0_out", 32'(o16), 32'h1234);
        check("lsl0_c", 32'(c16), 32'd0);

        // Back-to-back mix checked by the scoreboard
        p = pulses16;
        issue16(16'h8003, 16'h0004, 3'b100, 1'b1);
        issue16(16'h8003, 16'h0002, 3'b101, 1'b1);
        issue16(16'h0003, 16'h0005, 3'b001, 1'b1);
        issue16(16'h8000, 16'h0001, 3'b001, 1'b1);
        issue16(16'h00FF, 16'h1234, 3'b011, 1'b0);
        issue16(16'hFFFF, 16'h0001, 3'b000, 1'b1);
        @(negedge clk); iv16 = 1'b0;
        wait_done16();
        check("b2b_pulses16", 32'(pulses16 - p), 32'd6);

        // MUL with overflow: latency and ready-low window
        issue16(16'h0100, 16'h0100, 3'b111, 1'b1);
        mul_timing16(lat, lows);
        check("mul_latency16", 32'(lat), 32'd16);
        check("mul_ready_low16", 32'(lows), 32'd16);
        #1;
        wait_done16();
        check("mul_out", 32'(o16), 32'h0000);
        check("mul_flags", 32'({n16, v16, z16, c16}), 32'b0110);
        issue16(16'h0003, 16'h0007, 3'b111, 1'b1);
        @(negedge clk); iv16 = 1'b0;
        wait_done16();
        check("mul_small_out", 32'(o16), 32'h0015);
        check("mul_small_v", 32'(v16), 32'd0);

        // Reset five cycles into a multiply
        issue16(16'h0003, 16'h0005, 3'b111, 1'b1);
        @(negedge clk); iv16 = 1'b0;
        repeat (4) @(negedge clk);
        reset16 = 1'b1;
        q16.delete();
        fl16 = 4'b0;
        @(negedge clk);
        reset16 = 1'b0;
        #1;
        check("abort_out", 32'(o16), 32'd0);
        check("abort_flags", 32'({n16, v16, z16, c16}), 32'd0);
        check("abort_ready", 32'(ir16), 32'd1);
        p = pulses16;
        repeat (25) @(negedge clk);
        check("abort_no_pulse", 32'(pulses16 - p), 32'd0);
        issue16(16'h0002, 16'h0003, 3'b000, 1'b1);
        @(negedge clk); iv16 = 1'b0;
        wait_done16();
        check("post_abort_add", 32'(o16), 32'h0005);

        // 8-bit instance
        issue8(8'hFF, 8'h01, 3'b000, 1'b1);
        @(negedge clk); iv8 = 1'b0;
        wait_done8();
        check("add8_out", 32'(o8), 32'h00);
        check("add8_flags", 32'({n8, v8, z8, c8}), 32'b0011);

        issue8(8'h10, 8'h10, 3'b111, 1'b1);
        seen = 1'b0; ll = -1; lo = 0;
        for (int j = 1; j <= 40 && !seen; j++) begin
            @(negedge clk);
            if (j == 1) iv8 = 1'b0;
            if (!ir8) lo++;
            if (ov8) begin seen = 1'b1; ll = j - 1; end
        end
        check("mul_latency8", 32'(ll), 32'd8);
        check("mul_ready_low8", 32'(lo), 32'd8);
        #1;
        wait_done8();
        check("mul8_out", 32'(o8), 32'h00);
        check("mul8_v", 32'(v8), 32'd1);

        p = pulses8;
        issue8(8'h01, 8'h02, 3'b000, 1'b1);
        issue8(8'h7F, 8'h01, 3'b000, 1'b1);
        issue8(8'h80, 8'h80, 3'b000, 1'b0);
        issue8(8'h40, 8'h40, 3'b000, 1'b1);
        @(negedge clk); iv8 = 1'b0;
        wait_done8();
        check("b2b_pulses8", 32'(pulses8 - p), 32'd4);
        check("b2b8_last_out", 32'(o8), 32'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
